// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through instruction queue between fetch and decode.
//
// A circular buffer of DEPTH entries, each holding an instruction and its PC. The head
// entry is presented combinationally on the decode side; ValidD is low and NOP_INSTR is
// driven whenever the queue holds nothing.
//
// Optional feature (compile-time macro FETCHQ_BYPASS_EN): when the queue is empty, an
// entry offered by fetch is forwarded to decode in the same cycle. It is consumed
// without being written if decode is not stalled, and written normally otherwise.
//
// Ports:
//   clk       in   single clock, rising-edge
//   reset     in   asynchronous active-high reset
//   ValidF    in   fetch offers an entry this cycle
//   InstrF    in   fetched instruction
//   PCF       in   PC of the fetched instruction
//   ReadyF    out  queue can accept a push (Count < DEPTH)
//   StallD    in   decode cannot consume the head this cycle
//   FlushE    in   redirect: discard every stored entry at the next edge
//   ValidD    out  head entry is valid
//   InstrD    out  head instruction (NOP_INSTR when empty)
//   PCD       out  head PC (0 when empty)
//   PCPlus4D  out  PCD + 4, modulo 2^XLEN
//   Count     out  number of stored entries
module fetch_queue #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ValidF,
    input  logic [XLEN-1:0]            InstrF,
    input  logic [XLEN-1:0]            PCF,
    output logic                       ReadyF,
    input  logic                       StallD,
    input  logic                       FlushE,
    output logic                       ValidD,
    output logic [XLEN-1:0]            InstrD,
    output logic [XLEN-1:0]            PCD,
    output logic [XLEN-1:0]            PCPlus4D,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic empty;
    logic push;
    logic pop;
    logic bypass_take;

    assign empty  = (count_q == '0);
    assign ReadyF = (count_q < FullCount);
    assign Count  = count_q;

    // Head selection: stored head first, then (optionally) the fetch-side bypass.
    always_comb begin
        ValidD      = 1'b0;
        InstrD      = NOP_INSTR;
        PCD         = '0;
        bypass_take = 1'b0;
        if (!empty) begin
            ValidD = 1'b1;
            InstrD = instr_mem_q[rd_ptr_q];
            PCD    = pc_mem_q[rd_ptr_q];
        end
`ifdef FETCHQ_BYPASS_EN
        // Gated by reset so outputs hold their reset values while reset is high.
        else if (ValidF && !FlushE && !reset) begin
            ValidD      = 1'b1;
            InstrD      = InstrF;
            PCD         = PCF;
            bypass_take = !StallD;
        end
`endif
    end

    assign PCPlus4D = PCD + XLEN'(4);

    // A bypassed entry that decode consumes directly is never written. ReadyF is taken
    // from the registered count, so a full queue refuses a push even when it pops.
    assign push = ValidF && ReadyF && !FlushE && !bypass_take;
    assign pop  = !empty && !StallD && !FlushE;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FlushE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; its contents are unobservable while the count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= InstrF;
            pc_mem_q[wr_ptr_q]    <= PCF;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized bench for fetch_queue.
// The reference is a pair of SystemVerilog queues holding (instr, pc) in push order.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            ValidF;
    logic [XLEN-1:0] InstrF;
    logic [XLEN-1:0] PCF;
    logic            ReadyF;
    logic            StallD;
    logic            FlushE;
    logic            ValidD;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic [2:0]      Count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc[$];

    fetch_queue #(
        .XLEN (XLEN),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ValidF  (ValidF),
        .InstrF  (InstrF),
        .PCF     (PCF),
        .ReadyF  (ReadyF),
        .StallD  (StallD),
        .FlushE  (FlushE),
        .ValidD  (ValidD),
        .InstrD  (InstrD),
        .PCD     (PCD),
        .PCPlus4D(PCPlus4D),
        .Count   (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference queue and the current inputs.
    task automatic check_outputs(input string tag);
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        if (mq_pc.size() != 0) begin
            ev = 1'b1; ei = mq_instr[0]; ep = mq_pc[0];
        end else if (BYPASS && ValidF && !FlushE && !reset) begin
            ev = 1'b1; ei = InstrF; ep = PCF;
        end else begin
            ev = 1'b0; ei = 32'h00000013; ep = 32'h0;
        end
        check({tag, ".ValidD"},   64'(ValidD),   64'(ev));
        check({tag, ".InstrD"},   64'(InstrD),   64'(ei));
        check({tag, ".PCD"},      64'(PCD),      64'(ep));
        check({tag, ".PCPlus4D"}, 64'(PCPlus4D), 64'(32'(ep + 32'd4)));
        check({tag, ".Count"},    64'(Count),    64'(mq_pc.size()));
        check({tag, ".ReadyF"},   64'(ReadyF),   64'(mq_pc.size() < DEPTH));
    endtask

    // Drive inputs now, check outputs, advance the reference and wait for the edge.
    task automatic apply(input string tag, input logic vf, input logic [31:0] instr,
                         input logic [31:0] pc, input logic stall, input logic flush);
        int sz;
        bit take, do_pop, do_push;
        ValidF = vf; InstrF = instr; PCF = pc; StallD = stall; FlushE = flush;
        #1;
        check_outputs(tag);
        sz = mq_pc.size();
        if (flush) begin
            mq_instr.delete();
            mq_pc.delete();
        end else begin
            take    = BYPASS && (sz == 0) && vf && !stall;
            do_pop  = (sz > 0) && !stall;
            do_push = vf && (sz < DEPTH) && !take;
            if (do_pop) begin
                void'(mq_instr.pop_front());
                void'(mq_pc.pop_front());
            end
            if (do_push) begin
                mq_instr.push_back(instr);
                mq_pc.push_back(pc);
            end
        end
        @(posedge clk);
    endtask

    task automatic cycle(input string tag, input logic vf, input logic [31:0] instr,
                         input logic [31:0] pc, input logic stall, input logic flush);
        @(negedge clk);
        apply(tag, vf, instr, pc, stall, flush);
    endtask

    initial begin
        reset = 1'b1; ValidF = 1'b0; InstrF = '0; PCF = '0; StallD = 1'b0; FlushE = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill with stall, then a fifth offer that must be ignored
        for (int i = 0; i < 4; i++)
            cycle("fill", 1'b1, 32'h00100093 + 32'(i), 32'(4 * i), 1'b1, 1'b0);
        cycle("full_offer", 1'b1, 32'hDEADBEEF, 32'h10, 1'b1, 1'b0);
        check("full.Count", 64'(Count), 64'd4);
        check("full.ReadyF", 64'(ReadyF), 64'd0);

        // Drain in order, then observe the empty head
        for (int i = 0; i < 4; i++)
            cycle("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("drained", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Continuous push and pop over ten entries
        for (int i = 0; i < 10; i++)
            cycle("stream", 1'b1, 32'h00200013 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
        cycle("stream_end", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle("stream_end", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Flush with a concurrent push at Count = 3
        for (int i = 0; i < 3; i++)
            cycle("pre_flush", 1'b1, 32'h00300013 + 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
        cycle("flush", 1'b1, 32'h0BADF00D, 32'h300, 1'b1, 1'b1);
        cycle("post_flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // PC at the top of the address space: PCPlus4D wraps to zero
        cycle("pc_wrap", 1'b1, 32'h00000073, 32'hFFFFFFFC, 1'b1, 1'b0);
        cycle("pc_wrap_head", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with two entries stored
        cycle("pre_reset", 1'b1, 32'h00400013, 32'h400, 1'b1, 1'b0);
        cycle("pre_reset", 1'b1, 32'h00400014, 32'h404, 1'b1, 1'b0);
        @(negedge clk);
        ValidF = 1'b0; StallD = 1'b1; FlushE = 1'b0;
        #1;
        check_outputs("before_async_reset");
        #1;
        reset = 1'b1;
        #1;
        mq_instr.delete();
        mq_pc.delete();
        check_outputs("async_reset");
        @(posedge clk);
        @(negedge clk);
        // First edge after deassertion must accept a push
        reset = 1'b0;
        apply("post_reset_push", 1'b1, 32'h00500013, 32'h500, 1'b1, 1'b0);
        cycle("post_reset_head", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle("clear", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

`ifdef FETCHQ_BYPASS_EN
        // Same-cycle bypass from an empty queue
        @(negedge clk);
        ValidF = 1'b1; InstrF = 32'h00500093; PCF = 32'h600; StallD = 1'b0; FlushE = 1'b0;
        #1;
        check("bypass.ValidD", 64'(ValidD), 64'd1);
        check("bypass.InstrD", 64'(InstrD), 64'h00500093);
        @(posedge clk);
        #1;
        check("bypass.Count", 64'(Count), 64'd0);
`endif

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            logic        vf, st, fl;
            logic [31:0] ins, pc;
            vf  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            ins = $urandom;
            pc  = (i % 50 == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            cycle("random", vf, ins, pc, st, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of instruction and PC fields.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013: value driven on InstrD when empty.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ValidF  input  1  fetch offers an entry this cycle.
REQ-007 SHALL have port InstrF  input  XLEN  fetched instruction.
REQ-008 SHALL have port PCF  input  XLEN  PC of the fetched instruction.
REQ-009 SHALL have port ReadyF  output  1  queue can accept a push.
REQ-010 SHALL have port StallD  input  1  decode cannot consume the head this cycle.
REQ-011 SHALL have port FlushE  input  1  taken branch or jump redirect (PCSrcE); discard all entries.
REQ-012 SHALL have port ValidD  output  1  head entry is valid.
REQ-013 SHALL have port InstrD  output  XLEN  head instruction.
REQ-014 SHALL have port PCD  output  XLEN  head PC.
REQ-015 SHALL have port PCPlus4D  output  XLEN  PCD + 4, modulo 2^XLEN.
REQ-016 SHALL have port Count  output  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-017 SHALL be a first-word-fall-through circular buffer: head fields are driven combinationally from storage.
REQ-018 SHALL push when ValidF && ReadyF && !FlushE, and pop when ValidD && !StallD && !FlushE.
REQ-019 SHALL drive ReadyF = (Count < DEPTH); no push-through when full, even if a pop occurs in the same cycle.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL update Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL ignore a pop request when empty and a push offer when full; no state change results.
REQ-023 SHALL, on FlushE, clear Count and both pointers at the next edge; FlushE overrides any push or pop in that cycle.
REQ-024 SHALL drive ValidD = (Count != 0) and, when ValidD = 0, InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 4.
REQ-025 SHALL give a pushed entry a minimum latency of one cycle to ValidD; the Configuration section defines the exception.
REQ-026 SHALL deliver entries in push order with no loss or duplication between flushes.

Reset
REQ-027 SHALL, while reset is high, asynchronously force Count = 0, both pointers = 0, ValidD = 0, ReadyF = 1, InstrD = NOP_INSTR, PCD = 0 and PCPlus4D = 4.
REQ-028 SHALL discard in-flight entries if reset asserts mid-operation, and SHALL accept a push on the first rising edge after reset deasserts.
REQ-029 SHALL NOT reset entry storage contents; they are unobservable while Count = 0.

Configuration
REQ-030 SHALL support macro FETCHQ_BYPASS_EN.
REQ-031 With FETCHQ_BYPASS_EN defined, when Count = 0, ValidF = 1 and FlushE = 0, the block SHALL assert ValidD in the same cycle with InstrD = InstrF and PCD = PCF.
REQ-032 In that bypass case, if StallD = 0 the entry SHALL be consumed without being written (Count stays 0); if StallD = 1 it SHALL be written normally.
REQ-033 Without FETCHQ_BYPASS_EN, no combinational path SHALL exist from ValidF, InstrF or PCF to any output.

Verification
REQ-034 Reset, then push PCF = 0x0/0x4/0x8/0xC with StallD = 1 -> Count = 4, ReadyF = 0, fifth offer ignored.
REQ-035 From full, StallD = 0 for 4 cycles -> PCD = 0x0, 0x4, 0x8, 0xC with PCPlus4D = PCD + 4, then ValidD = 0 and InstrD = 0x00000013.
REQ-036 Continuous push and pop over 10 entries with DEPTH = 4 -> pointers wrap, Count steady at 1, order preserved.
REQ-037 Count = 3 with FlushE = 1 and ValidF = 1 in the same cycle -> next cycle Count = 0, ValidD = 0, pushed entry absent.
REQ-038 Reset asserted asynchronously mid-cycle with Count = 2 -> outputs return to reset values immediately, without waiting for a clock edge.
REQ-039 With FETCHQ_BYPASS_EN, empty queue, ValidF = 1, InstrF = 0x00500093, StallD = 0 -> same-cycle ValidD = 1 and InstrD = 0x00500093, and Count stays 0.
